ss_adc_conv_ctrl: RTL and testbench

- Conversion sequencer for the single-slope row ADC (per-pixel rising-edge capture of a free-running 8-bit counter).
- On each frame-row request it:
  - settles the ramp DAC;
  - pulses the ADC reset so the ADC counter and the controller's ramp code start aligned;
  - runs a full ramp;
  - snapshots all captured codes into a shadow buffer;
  - streams the codes out one pixel per handshake.
- Sits between the row-timing/frame controller (start/done) and the readout/serializer (valid/ready).

---
 rtl/ss_adc_conv_ctrl.sv | 122 ++++++++++++
 tb/tb_ss_adc_conv_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ss_adc_conv_ctrl.sv
// Conversion sequencer for a single-slope row ADC: settle, ADC reset, ramp, capture, readout.
// Optional macro SS_ADC_CONT_EN adds a 'cont' input for back-to-back rows without returning to IDLE.
module ss_adc_conv_ctrl #(
  parameter int NUM_PIXELS    = 20,
  parameter int CNT_W         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int IDX_W         = $clog2(NUM_PIXELS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
`ifdef SS_ADC_CONT_EN
  input  logic                        cont,
`endif
  output logic                        busy,
  output logic                        adc_rst,
  output logic                        ramp_en,
  output logic [CNT_W-1:0]            ramp_code,
  input  logic [NUM_PIXELS*CNT_W-1:0] stored_values,
  output logic                        rd_valid,
  input  logic                        rd_ready,
  output logic [CNT_W-1:0]            rd_data,
  output logic [IDX_W-1:0]            rd_idx,
  output logic                        done
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_ADC_RST,
    S_RAMP,
    S_CAPTURE,
    S_READOUT,
    S_DONE
  } state_t;

  state_t                        state_q, state_d;
  logic [SET_W-1:0]              settle_q, settle_d;
  logic [CNT_W-1:0]              ramp_q, ramp_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [NUM_PIXELS*CNT_W-1:0]   shadow_q, shadow_d;
  logic                          cont_en;

`ifdef SS_ADC_CONT_EN
  assign cont_en = cont;
`else
  assign cont_en = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      settle_q <= '0;
      ramp_q   <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      ramp_q   <= ramp_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    ramp_d   = ramp_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_SETTLE;
          settle_d = '0;
        end
      end
      S_SETTLE: begin
        if (settle_q == SET_W'(SETTLE_CYCLES - 1)) state_d = S_ADC_RST;
        else settle_d = settle_q + 1'b1;
      end
      S_ADC_RST: begin
        ramp_d  = '0;
        state_d = S_RAMP;
      end
      S_RAMP: begin
        // The ramp counter free-runs in lockstep with the ADC counter released by adc_rst.
        ramp_d = ramp_q + 1'b1;
        if (ramp_q == '1) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        shadow_d = stored_values;
        idx_d    = '0;
        state_d  = S_READOUT;
      end
      S_READOUT: begin
        if (rd_ready) begin
          if (idx_q == IDX_W'(NUM_PIXELS - 1)) state_d = S_DONE;
          else idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        settle_d = '0;
        state_d  = cont_en ? S_SETTLE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy      = (state_q != S_IDLE);
  assign adc_rst   = reset | (state_q == S_ADC_RST);
  assign ramp_en   = (state_q == S_RAMP);
  assign ramp_code = ramp_en ? ramp_q : '0;
  assign rd_valid  = (state_q == S_READOUT);
  assign rd_data   = rd_valid ? shadow_q[idx_q*CNT_W +: CNT_W] : '0;
  assign rd_idx    = rd_valid ? idx_q : '0;
  assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_ss_adc_conv_ctrl.sv
// Self-checking bench for ss_adc_conv_ctrl: behavioural ADC with per-pixel thresholds,
// expected codes and timing derived from the thresholds and the documented latencies.
module tb_ss_adc_conv_ctrl;

  localparam int NP = 20;
  localparam int CW = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic           rd_ready = 1'b0;
  logic           busy, adc_rst, ramp_en, rd_valid, done;
  logic [CW-1:0]  ramp_code, rd_data;
  logic [4:0]     rd_idx;
  logic [NP*CW-1:0] stored_values;
`ifdef SS_ADC_CONT_EN
  logic           cont = 1'b0;
`endif

  always #5 clk = ~clk;

  ss_adc_conv_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
`ifdef SS_ADC_CONT_EN
    .cont          (cont),
`endif
    .busy          (busy),
    .adc_rst       (adc_rst),
    .ramp_en       (ramp_en),
    .ramp_code     (ramp_code),
    .stored_values (stored_values),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_data       (rd_data),
    .rd_idx        (rd_idx),
    .done          (done)
  );

  // Behavioural ADC: free-running counter cleared by adc_rst, each pixel latches the
  // counter on the first cycle its comparator (ramp_code >= threshold) is high.
  int            thr [NP];
  logic [CW-1:0] stored [NP];
  bit            captured [NP];
  logic [CW-1:0] adc_cnt = '0;
  bit            glitch_en = 1'b0;

  always @(posedge clk) begin
    if (adc_rst) begin
      adc_cnt <= '0;
      for (int i = 0; i < NP; i++) begin
        stored[i]   <= '0;
        captured[i] <= 1'b0;
      end
    end else begin
      adc_cnt <= adc_cnt + 1'b1;
      for (int i = 0; i < NP; i++) begin
        if (!captured[i] && ramp_en && (int'(ramp_code) >= thr[i])) begin
          stored[i]   <= adc_cnt;
          captured[i] <= 1'b1;
        end
      end
      if (glitch_en) stored[2] <= adc_cnt;
    end
  end

  always_comb begin
    stored_values = '0;
    for (int i = 0; i < NP; i++) stored_values[i*CW +: CW] = stored[i];
  end

  int checks = 0;
  int errors = 0;

  int exp_code [NP];
  logic [CW-1:0] got_data [$];
  int got_idx [$];
  int done_times [$];
  int t_adcrst, n_adcrst, t_first_valid, t_last_xfer;
  int n_done, n_overlap, n_ramp_err, n_unstable, n_busy_low;

  // A pixel reads the ramp code at which its comparator first rose, or 0 if it never did.
  function automatic void set_expected();
    for (int i = 0; i < NP; i++) exp_code[i] = (thr[i] < 256) ? thr[i] : 0;
  endfunction

  function automatic int count_code_errs(input int base);
    int n = 0;
    for (int i = 0; i < NP; i++) begin
      if (base + i >= got_data.size()) n++;
      else if (int'(got_data[base+i]) != exp_code[i] || got_idx[base+i] != i) n++;
    end
    return n;
  endfunction

  task automatic run_row(input int mode, input int cycles, input bit poke,
                         input bit glitch, input int rows);
    int rcnt = 0;
    bit prev_stall = 1'b0;
    logic [CW-1:0] prev_data = '0;
    logic [4:0] prev_idx = '0;
    got_data.delete(); got_idx.delete(); done_times.delete();
    t_adcrst = -1; n_adcrst = 0; t_first_valid = -1; t_last_xfer = -1;
    n_done = 0; n_overlap = 0; n_ramp_err = 0; n_unstable = 0; n_busy_low = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= cycles; k++) begin
      @(negedge clk);
      start = poke && (k == 100 || k == 270);
      glitch_en = glitch && (k >= 263);
      if (adc_rst === 1'b1) begin
        n_adcrst++;
        if (t_adcrst < 0) t_adcrst = k;
      end
      if (busy !== 1'b1 && done_times.size() < rows) n_busy_low++;
      case (mode)
        0: rd_ready = 1'b1;
        1: rd_ready = ((rcnt % 4) == 0) || ((rcnt % 4) == 3);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      if (rd_valid === 1'b1) rcnt++;
      if (prev_stall && (rd_valid !== 1'b1 || rd_data !== prev_data || rd_idx !== prev_idx))
        n_unstable++;
      if (rd_valid === 1'b1 && t_first_valid < 0) t_first_valid = k;
      if (rd_valid === 1'b1 && rd_ready) begin
        got_data.push_back(rd_data);
        got_idx.push_back(int'(rd_idx));
        t_last_xfer = k;
      end
      prev_stall = (rd_valid === 1'b1) && !rd_ready;
      prev_data  = rd_data;
      prev_idx   = rd_idx;
      if (done === 1'b1) begin
        n_done++;
        done_times.push_back(k);
        if (rd_valid === 1'b1) n_overlap++;
      end
      if (ramp_en === 1'b1 && ramp_code !== adc_cnt) n_ramp_err++;
`ifdef SS_ADC_CONT_EN
      if (done_times.size() >= rows) cont = 1'b0;
`endif
    end
    rd_ready = 1'b0;
    start = 1'b0;
    glitch_en = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (adc_rst !== 1'b1 || busy !== 1'b0 || ramp_en !== 1'b0 || ramp_code !== 8'd0 ||
          rd_valid !== 1'b0 || rd_data !== 8'd0 || rd_idx !== 5'd0 || done !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_outputs: got adc_rst=%b busy=%b ramp_en=%b code=%0d valid=%b data=%0d idx=%0d done=%b, expected 1 and all others 0",
                 adc_rst, busy, ramp_en, ramp_code, rd_valid, rd_data, rd_idx, done);
      end
    end
    reset = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || adc_rst !== 1'b0 || rd_valid !== 1'b0 || done !== 1'b0 || ramp_en !== 1'b0) begin
        errors++;
        $display("[TB] FAIL idle_outputs: got busy=%b adc_rst=%b valid=%b done=%b ramp_en=%b, expected all 0",
                 busy, adc_rst, rd_valid, done, ramp_en);
      end
    end
  endtask

  task automatic test_single();
    int n;
    for (int i = 0; i < NP; i++) thr[i] = 10*i + 5;
    set_expected();
    run_row(0, 300, 1'b0, 1'b0, 1);
    checks++;
    if (t_adcrst !== 5 || n_adcrst !== 1) begin
      errors++;
      $display("[TB] FAIL single_adc_rst: got cycle %0d count %0d, expected cycle 5 count 1", t_adcrst, n_adcrst);
    end
    checks++;
    if (t_first_valid !== 263) begin
      errors++;
      $display("[TB] FAIL single_first_valid: got %0d expected 263", t_first_valid);
    end
    checks++;
    if (got_data.size() !== NP || t_last_xfer !== 282) begin
      errors++;
      $display("[TB] FAIL single_xfers: got %0d ending cycle %0d, expected %0d ending 282", got_data.size(), t_last_xfer, NP);
    end
    n = count_code_errs(0);
    checks++;
    if (n !== 0) begin
      errors++;
      $display("[TB] FAIL single_codes: got %0d bad pixels expected 0", n);
    end
    checks++;
    if (n_done !== 1 || t_done_first() !== 283 || n_overlap !== 0) begin
      errors++;
      $display("[TB] FAIL single_done: got count %0d cycle %0d overlap %0d, expected 1 at 283 overlap 0",
               n_done, t_done_first(), n_overlap);
    end
    checks++;
    if (n_ramp_err !== 0) begin
      errors++;
      $display("[TB] FAIL single_ramp_align: got %0d misaligned cycles expected 0", n_ramp_err);
    end
  endtask

  function automatic int t_done_first();
    return (done_times.size() > 0) ? done_times[0] : -1;
  endfunction

  task automatic test_backpressure();
    int n;
    for (int i = 0; i < NP; i++) thr[i] = 200 - 7*i;
    set_expected();
    run_row(1, 360, 1'b0, 1'b0, 1);
    checks++;
    if (n_unstable !== 0) begin
      errors++;
      $display("[TB] FAIL bp_stable: got %0d unstable stalls expected 0", n_unstable);
    end
    n = count_code_errs(0);
    checks++;
    if (n !== 0 || got_data.size() !== NP) begin
      errors++;
      $display("[TB] FAIL bp_codes: got %0d bad pixels, %0d transfers, expected 0 and %0d", n, got_data.size(), NP);
    end
    checks++;
    if (n_done !== 1 || t_done_first() !== t_last_xfer + 1) begin
      errors++;
      $display("[TB] FAIL bp_done: got count %0d at %0d, expected 1 at %0d", n_done, t_done_first(), t_last_xfer + 1);
    end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < NP; i++) thr[i] = 30 + i;
    thr[0] = 255;
    thr[1] = 1000;
    thr[2] = 50;
    set_expected();
    run_row(0, 300, 1'b0, 1'b1, 1);
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (p >= got_data.size() || int'(got_data[p]) !== exp_code[p]) begin
        errors++;
        $display("[TB] FAIL boundary_pixel%0d: got %0d expected %0d", p,
                 (p < got_data.size()) ? int'(got_data[p]) : -1, exp_code[p]);
      end
    end
  endtask

  task automatic test_start_busy();
    int n;
    for (int i = 0; i < NP; i++) thr[i] = 12*i;
    set_expected();
    run_row(0, 400, 1'b1, 1'b0, 1);
    n = count_code_errs(0);
    checks++;
    if (n_done !== 1 || n_adcrst !== 1 || n !== 0) begin
      errors++;
      $display("[TB] FAIL start_ignored: got done=%0d adc_rst=%0d bad=%0d, expected 1 1 0", n_done, n_adcrst, n);
    end
  endtask

  task automatic test_reset_mid_ramp();
    bit found = 1'b0;
    int n_late_done = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 300 && !found; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (ramp_en === 1'b1 && ramp_code === 8'd100) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL mid_reset_reach: got no ramp_code 100 within 300 cycles, expected one");
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ramp_en !== 1'b0 || ramp_code !== 8'd0 || adc_rst !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_reset_abort: got busy=%b ramp_en=%b code=%0d adc_rst=%b, expected 0 0 0 1",
               busy, ramp_en, ramp_code, adc_rst);
    end
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) n_late_done++;
    end
    checks++;
    if (n_late_done !== 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_no_done: got %0d busy/done cycles expected 0", n_late_done);
    end
    for (int i = 0; i < NP; i++) thr[i] = 250 - 3*i;
    set_expected();
    run_row(0, 300, 1'b0, 1'b0, 1);
    checks++;
    if (t_done_first() !== 283 || count_code_errs(0) !== 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_rerun: got done at %0d bad=%0d, expected 283 and 0", t_done_first(), count_code_errs(0));
    end
  endtask

  task automatic test_random();
    int n;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < NP; i++) thr[i] = int'($urandom_range(0, 299));
      thr[$urandom_range(0, NP-1)] = 255;
      set_expected();
      run_row(2, 520, 1'b0, 1'b0, 1);
      n = count_code_errs(0);
      checks++;
      if (n !== 0 || got_data.size() !== NP || n_done !== 1 || n_unstable !== 0 || n_overlap !== 0) begin
        errors++;
        $display("[TB] FAIL random_row%0d: got bad=%0d xfers=%0d done=%0d unstable=%0d overlap=%0d, expected 0 %0d 1 0 0",
                 it, n, got_data.size(), n_done, n_unstable, n_overlap, NP);
      end
    end
  endtask

`ifdef SS_ADC_CONT_EN
  task automatic test_cont();
    for (int i = 0; i < NP; i++) thr[i] = 9*i + 3;
    set_expected();
    cont = 1'b1;
    run_row(0, 650, 1'b0, 1'b0, 2);
    checks++;
    if (done_times.size() !== 2 || done_times[0] !== 283 || done_times[1] !== 566) begin
      errors++;
      $display("[TB] FAIL cont_done_times: got %0d pulses first %0d, expected 2 at 283 and 566",
               done_times.size(), t_done_first());
    end
    checks++;
    if (n_busy_low !== 0) begin
      errors++;
      $display("[TB] FAIL cont_busy: got %0d idle cycles expected 0", n_busy_low);
    end
    checks++;
    if (count_code_errs(0) !== 0 || count_code_errs(NP) !== 0) begin
      errors++;
      $display("[TB] FAIL cont_codes: got bad row0=%0d row1=%0d expected 0 0", count_code_errs(0), count_code_errs(NP));
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < NP; i++) thr[i] = 1000;
    test_reset();
    test_single();
    test_backpressure();
    test_boundary();
    test_start_busy();
    test_reset_mid_ramp();
    test_random();
`ifdef SS_ADC_CONT_EN
    test_cont();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
